// File: rtl/wb_arbiter.sv
// wb_arbiter: funnels ALU, LSU and FPU results into one registered
// register-file write port and tracks which registers still await a result.
// ALU results always win; LSU and FPU share the remaining slot round-robin.
// Optional build macro ZERO_REG_EN: register 0 is hardwired, so results to
// address 0 complete their handshake without writing, and issues to address 0
// never mark it pending.
module wb_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              fpu_valid,
  output logic              fpu_ready,
  input  logic [ADDR_W-1:0] fpu_addr,
  input  logic [DATA_W-1:0] fpu_data,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

`ifdef ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef enum logic {
    GRANT_LSU = 1'b0,
    GRANT_FPU = 1'b1
  } grant_t;

  grant_t            last_grant;
  logic [NREG-1:0]   pending;
  logic              lsu_xfer;
  logic              fpu_xfer;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              wr_en;
  logic              iss_en;
  logic              set_inc;
  logic              clr_dec;

  // LSU/FPU readies: blocked by reset or an ALU result, ties broken against the last winner
  always_comb begin
    lsu_ready = 1'b0;
    fpu_ready = 1'b0;
    if (!rst && !alu_valid) begin
      if (lsu_valid && fpu_valid) begin
        if (last_grant == GRANT_FPU) lsu_ready = 1'b1;
        else                         fpu_ready = 1'b1;
      end else begin
        lsu_ready = lsu_valid;
        fpu_ready = fpu_valid;
      end
    end
  end

  // Select the single result accepted this cycle and decide its effect on pending state
  always_comb begin
    lsu_xfer = lsu_valid && lsu_ready;
    fpu_xfer = fpu_valid && fpu_ready;
    accept   = 1'b0;
    acc_addr = '0;
    acc_data = '0;
    if (alu_valid) begin
      accept   = 1'b1;
      acc_addr = alu_addr;
      acc_data = alu_data;
    end else if (lsu_xfer) begin
      accept   = 1'b1;
      acc_addr = lsu_addr;
      acc_data = lsu_data;
    end else if (fpu_xfer) begin
      accept   = 1'b1;
      acc_addr = fpu_addr;
      acc_data = fpu_data;
    end
    wr_en   = accept && !(ZERO_EN && (acc_addr == '0));
    iss_en  = iss_valid && !(ZERO_EN && (iss_addr == '0));
    set_inc = iss_en && !pending[iss_addr];
    clr_dec = accept && pending[acc_addr] && !(iss_en && (iss_addr == acc_addr));
  end

  // Remember which of LSU/FPU won the most recent handshake
  always_ff @(posedge clk) begin
    if (rst)           last_grant <= GRANT_FPU;
    else if (lsu_xfer) last_grant <= GRANT_LSU;
    else if (fpu_xfer) last_grant <= GRANT_FPU;
  end

  // Register the accepted result; address/data hold whenever nothing is written
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= wr_en;
      if (wr_en) begin
        wa <= acc_addr;
        wd <= acc_data;
      end
    end
  end

  // Pending vector: acceptance clears, issue sets, and the later set wins on a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (accept) pending[acc_addr] <= 1'b0;
      if (iss_en) pending[iss_addr] <= 1'b1;
    end
  end

  // Pending count tracks real bit transitions only, so it always equals the popcount
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= '0;
    end else begin
      case ({set_inc, clr_dec})
        2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
        2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  assign chk_busy = pending[chk_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. Scenario tasks push the
// writes they expect; a monitor pops them one cycle after acceptance.
`timescale 1ns/1ps
module tb_wb_arbiter;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        alu_valid, lsu_valid, fpu_valid, iss_valid;
  logic        lsu_ready, fpu_ready;
  logic [5:0]  alu_addr, lsu_addr, fpu_addr, iss_addr, chk_addr, wa;
  logic [31:0] alu_data, lsu_data, fpu_data, wd;
  logic        we, chk_busy;
  logic [6:0]  pend_cnt;

  logic        rst_req;
  logic [5:0]  chk_req;
  wr_t         exp_q[$];
  int          vectors;
  int          miscompares;

  wb_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_addr(fpu_addr), .fpu_data(fpu_data),
    .we(we), .wa(wa), .wd(wd),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .chk_addr(chk_addr), .chk_busy(chk_busy), .pend_cnt(pend_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ns
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: every cycle the write port must match the queue head or stay idle
  always @(posedge clk) begin
    wr_t e;
    #3;
    vectors++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (we !== 1'b1 || wa !== e.addr || wd !== e.data) begin
        miscompares++;
        $display("[TB] FAIL write_port: got we=%b wa=%0d wd=%h, expected we=1 wa=%0d wd=%h",
                 we, wa, wd, e.addr, e.data);
      end
    end else if (we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_write: got we=%b wa=%0d, expected we=0", we, wa);
    end
  end

  // Apply one cycle of stimulus just after the falling edge and let it settle
  task automatic drive(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [5:0] la, input logic [31:0] ld,
                       input logic fv, input logic [5:0] fa, input logic [31:0] fd,
                       input logic iv, input logic [5:0] ia);
    @(negedge clk);
    rst       = rst_req;
    chk_addr  = chk_req;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    fpu_valid = fv; fpu_addr = fa; fpu_data = fd;
    iss_valid = iv; iss_addr = ia;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input logic [5:0] a);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a);
  endtask

  task automatic test_reset();
    rst_req = 1'b1;
    drive(0, 0, 0, 1, 6'd2, 32'h1, 1, 6'd3, 32'h2, 1, 6'd4);
    vectors++;
    if (lsu_ready !== 1'b0 || fpu_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got lsu=%b fpu=%b, expected 0 0", lsu_ready, fpu_ready);
    end
    idle();
    rst_req = 1'b0;
    idle();
    vectors++;
    if (pend_cnt !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_cnt: got %0d, expected 0", pend_cnt);
    end
  endtask

  task automatic test_alu_write();
    drive(1, 6'd5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{addr: 6'd5, data: 32'h12345678});
    idle();
    idle();
  endtask

  task automatic test_round_robin();
    drive(1, 6'd1, 32'hA1A1A1A1, 1, 6'd2, 32'hB2B2B2B2, 1, 6'd3, 32'hC3C3C3C3, 0, 0);
    vectors++;
    if (lsu_ready !== 1'b0 || fpu_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rr_alu_block: got lsu=%b fpu=%b, expected 0 0", lsu_ready, fpu_ready);
    end
    exp_q.push_back('{addr: 6'd1, data: 32'hA1A1A1A1});
    drive(0, 0, 0, 1, 6'd2, 32'hB2B2B2B2, 1, 6'd3, 32'hC3C3C3C3, 0, 0);
    vectors++;
    if (lsu_ready !== 1'b1 || fpu_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rr_first_tie: got lsu=%b fpu=%b, expected 1 0", lsu_ready, fpu_ready);
    end
    exp_q.push_back('{addr: 6'd2, data: 32'hB2B2B2B2});
    drive(0, 0, 0, 1, 6'd4, 32'hD4D4D4D4, 1, 6'd3, 32'hC3C3C3C3, 0, 0);
    vectors++;
    if (lsu_ready !== 1'b0 || fpu_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rr_second_tie: got lsu=%b fpu=%b, expected 0 1", lsu_ready, fpu_ready);
    end
    exp_q.push_back('{addr: 6'd3, data: 32'hC3C3C3C3});
    drive(0, 0, 0, 1, 6'd4, 32'hD4D4D4D4, 0, 0, 0, 0, 0);
    vectors++;
    if (lsu_ready !== 1'b1 || fpu_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rr_lone_lsu: got lsu=%b fpu=%b, expected 1 0", lsu_ready, fpu_ready);
    end
    exp_q.push_back('{addr: 6'd4, data: 32'hD4D4D4D4});
    idle();
    idle();
  endtask

  task automatic test_pending();
    chk_req = 6'd7;
    issue(6'd7);
    issue(6'd7);
    vectors++;
    if (chk_busy !== 1'b1 || pend_cnt !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL pend_set: got busy=%b cnt=%0d, expected 1 1", chk_busy, pend_cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 6'd7, 32'hF00D0007, 0, 0);
    vectors++;
    if (fpu_ready !== 1'b1 || chk_busy !== 1'b1 || pend_cnt !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL pend_dup_issue: got rdy=%b busy=%b cnt=%0d, expected 1 1 1",
               fpu_ready, chk_busy, pend_cnt);
    end
    exp_q.push_back('{addr: 6'd7, data: 32'hF00D0007});
    drive(0, 0, 0, 1, 6'd8, 32'h00000008, 0, 0, 0, 0, 0);
    vectors++;
    if (chk_busy !== 1'b0 || pend_cnt !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL pend_clear: got busy=%b cnt=%0d, expected 0 0", chk_busy, pend_cnt);
    end
    exp_q.push_back('{addr: 6'd8, data: 32'h00000008});
    idle();
    vectors++;
    if (pend_cnt !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL pend_nonpending_ack: got cnt=%0d, expected 0", pend_cnt);
    end
  endtask

  task automatic test_issue_wins();
    chk_req = 6'd9;
    issue(6'd9);
    drive(0, 0, 0, 1, 6'd9, 32'h99999999, 0, 0, 0, 1, 6'd9);
    vectors++;
    if (lsu_ready !== 1'b1 || pend_cnt !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL collide_pre: got rdy=%b cnt=%0d, expected 1 1", lsu_ready, pend_cnt);
    end
    exp_q.push_back('{addr: 6'd9, data: 32'h99999999});
    drive(1, 6'd9, 32'h09090909, 0, 0, 0, 0, 0, 0, 1, 6'd12);
    vectors++;
    if (chk_busy !== 1'b1 || pend_cnt !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL collide_issue_wins: got busy=%b cnt=%0d, expected 1 1", chk_busy, pend_cnt);
    end
    exp_q.push_back('{addr: 6'd9, data: 32'h09090909});
    chk_req = 6'd12;
    idle();
    vectors++;
    if (chk_busy !== 1'b1 || pend_cnt !== 7'd1) begin
      miscompares++;
      $display("[TB] FAIL swap_count: got busy=%b cnt=%0d, expected 1 1", chk_busy, pend_cnt);
    end
    drive(1, 6'd12, 32'h0000000C, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{addr: 6'd12, data: 32'h0000000C});
    idle();
    vectors++;
    if (chk_busy !== 1'b0 || pend_cnt !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL swap_clear: got busy=%b cnt=%0d, expected 0 0", chk_busy, pend_cnt);
    end
  endtask

  task automatic test_reset_inflight();
    issue(6'd20);
    issue(6'd21);
    drive(1, 6'd30, 32'h3030CAFE, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (pend_cnt !== 7'd2) begin
      miscompares++;
      $display("[TB] FAIL inflight_cnt: got %0d, expected 2", pend_cnt);
    end
    exp_q.push_back('{addr: 6'd30, data: 32'h3030CAFE});
    rst_req = 1'b1;
    idle();
    rst_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk_req = 6'(i);
      idle();
      vectors++;
      if (chk_busy !== 1'b0 || pend_cnt !== 7'd0) begin
        miscompares++;
        $display("[TB] FAIL post_reset_clear: addr %0d got busy=%b cnt=%0d, expected 0 0",
                 i, chk_busy, pend_cnt);
      end
    end
  endtask

  task automatic test_zero_reg();
    chk_req = 6'd0;
    drive(1, 6'd0, 32'h0BADF00D, 0, 0, 0, 0, 0, 0, 0, 0);
`ifndef ZERO_REG_EN
    exp_q.push_back('{addr: 6'd0, data: 32'h0BADF00D});
`endif
    issue(6'd0);
    idle();
`ifdef ZERO_REG_EN
    vectors++;
    if (pend_cnt !== 7'd0 || chk_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_reg_issue: got cnt=%0d busy=%b, expected 0 0", pend_cnt, chk_busy);
    end
`else
    vectors++;
    if (pend_cnt !== 7'd1 || chk_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reg0_issue: got cnt=%0d busy=%b, expected 1 1", pend_cnt, chk_busy);
    end
    drive(1, 6'd0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back('{addr: 6'd0, data: 32'h00000000});
`endif
    idle();
    idle();
  endtask

  // Run every scenario in order, then confirm nothing expected was left unwritten
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_req     = 1'b1;
    chk_req     = '0;
    rst         = 1'b1;
    chk_addr    = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    fpu_valid = 1'b0; fpu_addr = '0; fpu_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
    $display("[TB] starting wb_arbiter bench");
    test_reset();
    test_alu_write();
    test_round_robin();
    test_pending();
    test_issue_wins();
    test_reset_inflight();
    test_zero_reg();
    idle();
    idle();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
